// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage.
// Executes mult/multu/div/divu (multi-cycle, results held pending until the
// countdown ends) and mthi/mtlo (single edge). Owns the architectural HI/LO.
//
// Ports:
//   clk    - clock, all state updates on posedge
//   reset  - synchronous, active-low
//   start  - EX-stage md instruction valid (qualified by md_op)
//   md_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   a, b   - rs / rt operands
//   busy   - multi-cycle operation in flight
//   stall  - busy, or a multi-cycle op being presented this cycle
//   hi, lo - HI / LO registers
//
// State table:
//   ST_IDLE | no operation in flight, new ops accepted
//   ST_BUSY | counting down; hi/lo take the pending result when count 1->0
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  count, count_nxt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    logic        is_long_op;
    logic        is_mult;
    logic        accept;
    logic        done;

    assign is_long_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                        (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign is_mult    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign accept     = start && (state == ST_IDLE);
    assign done       = (state == ST_BUSY) && (count == 4'd1);

    assign busy  = (state == ST_BUSY);
    assign stall = busy || (start && is_long_op);

    // Products: the low 64 bits of a 64x64 multiply of sign-extended operands
    // equal the signed 32x32 product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide through magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 without relying on signed-overflow behaviour of '/'.
    // A zero divisor is replaced by 1 only to keep the datapath X-free;
    // that result is discarded via pend_wr.
    logic [31:0] mag_a, mag_b, safe_mag_b, safe_b;
    logic [31:0] q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

    assign mag_a      = a[31] ? (~a + 32'd1) : a;
    assign mag_b      = b[31] ? (~b + 32'd1) : b;
    assign safe_mag_b = (b == 32'd0) ? 32'd1 : mag_b;
    assign safe_b     = (b == 32'd0) ? 32'd1 : b;
    assign q_mag      = mag_a / safe_mag_b;
    assign r_mag      = mag_a % safe_mag_b;
    assign quot_s     = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s      = a[31] ? (~r_mag + 32'd1) : r_mag;
    assign quot_u     = a / safe_b;
    assign rem_u      = a % safe_b;

    logic [31:0] res_hi, res_lo;
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = rem_s;         res_lo = quot_s;       end
            OP_DIVU:  begin res_hi = rem_u;         res_lo = quot_u;       end
            default:  ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            ST_IDLE: begin
                if (start && is_long_op) begin
                    state_nxt = ST_BUSY;
                    count_nxt = is_mult ? MULT_LOAD : DIV_LOAD;
                end
            end
            ST_BUSY: begin
                count_nxt = count - 4'd1;
                if (count == 4'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept && is_long_op) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                // Divide by zero still runs the full countdown but leaves HI/LO alone.
                pend_wr <= is_mult || (b != 32'd0);
            end
            if (accept && (md_op == OP_MTHI)) begin
                hi <= a;
            end
            if (accept && (md_op == OP_MTLO)) begin
                lo <= a;
            end
            if (done && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of posedges so far; "cycle c" is the interval after edge c.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference state: architectural HI/LO and the window of busy cycles.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          busy_from = 0;
    int          busy_until = 0;

    // Monitor: busy/stall every cycle, HI/LO whenever a scoreboard entry falls due.
    exp_t e;
    logic exp_busy, exp_stall;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_busy  = (cyc >= busy_from) && (cyc < busy_until);
            exp_stall = exp_busy || (start && (md_op >= 3'd1) && (md_op <= 3'd4));
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_busy);
            end
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL stall cyc=%0d got %b expected %b", cyc, stall, exp_stall);
            end
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (hi !== e.hi || lo !== e.lo) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got hi=%08h lo=%08h expected hi=%08h lo=%08h",
                             e.name, cyc, hi, lo, e.hi, e.lo);
                end
            end
        end
    end

    function automatic string op_name(input logic [2:0] op);
        case (op)
            3'd1: return "mult";
            3'd2: return "multu";
            3'd3: return "div";
            3'd4: return "divu";
            3'd5: return "mthi";
            3'd6: return "mtlo";
            default: return "none";
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            md_op = 3'd0;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        while (cyc + 1 <= busy_until) idle(1);
    endtask

    task automatic do_reset(input int n);
        exp_t keep[$];
        for (int i = 0; i < n; i++) begin
            keep.delete();
            foreach (sb[k]) if (sb[k].due <= cyc) keep.push_back(sb[k]);
            sb = keep;
            sb.push_back('{cyc + 1, 32'd0, 32'd0, "reset"});
            if (busy_until > cyc + 1) busy_until = cyc + 1;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            reset = 1'b0;
            start = 1'b0;
            md_op = 3'd0;
            @(posedge clk); #1;
        end
        reset = 1'b1;
    endtask

    // Drive one op for one edge and record what the architecture must do with it.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        int          edge_n;
        int          n;
        longint      sa, sb_v, prod, q, r;
        longint unsigned ua, ub, produ;
        logic [31:0] nh, nl;
        edge_n = cyc + 1;
        start  = 1'b1;
        md_op  = op;
        a      = va;
        b      = vb;
        if (edge_n > busy_until) begin
            nh = m_hi;
            nl = m_lo;
            n  = 0;
            sa   = longint'($signed(va));
            sb_v = longint'($signed(vb));
            ua   = longint'({32'd0, va});
            ub   = longint'({32'd0, vb});
            case (op)
                3'd1: begin prod = sa * sb_v; nh = prod[63:32]; nl = prod[31:0]; n = MULT_N; end
                3'd2: begin produ = ua * ub; nh = produ[63:32]; nl = produ[31:0]; n = MULT_N; end
                3'd3: begin
                    n = DIV_N;
                    if (vb != 32'd0) begin
                        q = sa / sb_v;
                        r = sa % sb_v;
                        nh = r[31:0];
                        nl = q[31:0];
                    end
                end
                3'd4: begin
                    n = DIV_N;
                    if (vb != 32'd0) begin
                        nh = va % vb;
                        nl = va / vb;
                    end
                end
                3'd5: nh = va;
                3'd6: nl = va;
                default: ;
            endcase
            if (n > 0) begin
                sb.push_back('{edge_n + n - 1, m_hi, m_lo, {op_name(op), "_hold"}});
                sb.push_back('{edge_n + n, nh, nl, op_name(op)});
                busy_from  = edge_n;
                busy_until = edge_n + n;
            end else begin
                sb.push_back('{edge_n, nh, nl, op_name(op)});
            end
            m_hi = nh;
            m_lo = nl;
        end
        @(posedge clk); #1;
        start = 1'b0;
        md_op = 3'd0;
    endtask

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        do_reset(2);

        // Activity followed by reset in the middle of a multiply.
        issue(3'd5, 32'hCAFE0000, 32'd0);
        issue(3'd1, 32'd3, 32'd5);
        idle(2);
        do_reset(2);

        issue(3'd1, 32'hFFFFFFFF, 32'h00000002); wait_idle();
        issue(3'd2, 32'hFFFFFFFF, 32'h00000002); wait_idle();
        issue(3'd3, 32'hFFFFFFF9, 32'd2);        wait_idle();
        issue(3'd4, 32'd7, 32'd2);               wait_idle();

        issue(3'd5, 32'h12345678, 32'd0);
        issue(3'd6, 32'h9ABCDEF0, 32'd0);
        issue(3'd3, 32'd55, 32'd0);              wait_idle();

        // mtlo presented during busy must be dropped.
        issue(3'd1, 32'h00001234, 32'h00000010);
        issue(3'd6, 32'h0000DEAD, 32'd0);
        wait_idle();

        // Reset in cycle 3 of a divide.
        issue(3'd3, 32'd100, 32'd7);
        idle(1);
        do_reset(2);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle();
        issue(3'd0, 32'h11111111, 32'h2);
        issue(3'd7, 32'h22222222, 32'h3);
        issue(3'd5, 32'hA5A5A5A5, 32'd0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) != 0) wait_idle();
            if ($urandom_range(0, 24) == 0) do_reset(1);
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
            idle($urandom_range(0, 2));
        end
        wait_idle();

        for (int i = 0; i < 100 && sb.size() > 0; i++) idle(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d entries outstanding expected 0", sb.size());
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the P6 five-stage MIPS pipeline. Executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers that mfhi/mflo read.
- Drives the busy/stall signal that the hazard unit uses to freeze D-stage md instructions while an operation is in flight.
- Results reach the GRF write-back trace only through later mfhi/mflo.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low; clock clk
start  input  1  EX-stage md instruction valid this cycle (qualified by md_op)
md_op  input  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=reserved (treated as none)
a  input  32  rs operand (forwarded)
b  input  32  rt operand (forwarded)
busy  output  1  multi-cycle operation in progress
stall  output  1  combinational: busy | (start & md_op in {1,2,3,4})
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: sampled on posedge; reset==0 forces busy=0, counter=0, hi=0, lo=0, pending result=0. Reset mid-operation aborts the operation: no HI/LO update, busy=0 on the next cycle.
- Accept: a posedge with reset==1, start==1, busy==0 accepts md_op. If start is high while busy==1, the op is ignored; upstream must hold it via stall.
- mult/multu: the 64-bit product (signed or unsigned) of a and b is captured into a pending register at the accept edge. Counter loads MULT_CYCLES, busy=1 after the edge.
- div/divu: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (signed case). Both are captured as pending at the accept edge. Counter loads DIV_CYCLES.
- div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (b==0): busy still runs DIV_CYCLES; HI/LO are left unchanged at completion.
- Countdown: each posedge with busy==1 decrements the counter. On the edge where the counter goes 1->0, hi/lo take the pending value and busy drops. For an accept at edge E, busy is high in cycles E..E+N-1, and new hi/lo are visible after edge E+N (N = MULT_CYCLES or DIV_CYCLES).
- mthi/mtlo: accepted with busy==0, they write hi (or lo) from a at that edge with no busy cycles. The other register is untouched.
- md_op none/reserved with start=1: no state change.
- hi/lo hold their old values throughout busy. mfhi/mflo issued during busy are stalled by the hazard unit, not by this block.
- No back-to-back overlap: a new op can be accepted at the edge where busy is 0, i.e. the cycle after completion.
- Pending product/quotient is computed combinationally from a,b at accept. A sequential iterative divider is permitted provided the visible latency and results match exactly.

Test Plan:
- Reset low for 2 cycles after arbitrary activity -> hi=0, lo=0, busy=0, stall=0.
- mult a=0xFFFFFFFF b=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=2 -> lo=3, hi=1.
- mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated on each edge, busy stays 0. Then div by b=0 -> after 10 cycles hi=0x12345678, lo=0x9ABCDEF0.
- mult issued; at cycle 2 of busy, start=1 with mtlo a=0xDEAD -> mtlo is ignored, stall=1 throughout busy, final lo=product low word. Then reset=0 at cycle 3 of a new div -> busy=0, hi=lo=0.
- Edge case: div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no X on outputs.
